spi_slave_ram_param: RTL and testbench

//  Parametrised successor of the SPI-slave + single-port-RAM top: SPI slave front end, command decoder and

---
 rtl/spi_ram_pkg.sv | 21 ++
 rtl/spi_ram_sp.sv | 37 +++
 rtl/spi_slave_ram_param.sv | 218 +++++++++++++++++++++
 tb/tb_spi_slave_ram_param.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI slave with internal RAM.
// Contents:
//   CMD_*        two-bit command codes carried in the first two payload-phase bits
//   spi_state_e  FSM state encoding of the frame receiver
// Optional feature macro used by the top level: SPI_RAM_AUTOINC_EN.
package spi_ram_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHK_CMD   = 3'd1,
        ST_WRITE     = 3'd2,
        ST_READ_ADD  = 3'd3,
        ST_READ_DATA = 3'd4
    } spi_state_e;

endpackage

// File: rtl/spi_ram_sp.sv
// Single-port RAM, synchronous write, registered (1-cycle) read.
// Ports:
//   clk_i    clock
//   we_i     write enable, writes wdata_i to addr_i
//   re_i     read enable, rdata_o updated with mem[addr_i] on the next edge
//   addr_i   shared read/write address
//   wdata_i  write data
//   rdata_o  registered read data
// Contents are intentionally not reset.
module spi_ram_sp #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_DEPTH  = 2**ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/spi_slave_ram_param.sv
// SPI slave front end, command decoder and internal RAM, parametrised in
// data width, address width and depth. clk is the SPI bit clock.
// Ports:
//   clk          SPI clock; MOSI sampled and MISO updated on the rising edge
//   rst_n        asynchronous active-low reset
//   SS_n         slave select, active low; one low period is one frame
//   MOSI         serial in, MSB first
//   MISO         serial out, MSB first
//   busy         high while the FSM is out of IDLE
//   frame_err    one-cycle pulse when SS_n rises before a frame is complete
//   dbg_state_o  current FSM state (debug)
// Frame: one IDLE->CHK_CMD cycle, one direction bit, then DATA_WIDTH+2 bits
// (cmd[1:0], payload MSB first). The command executes on the edge after the
// last bit, even if SS_n rises on that edge.
// Optional feature: define SPI_RAM_AUTOINC_EN for address auto-increment
// after data writes/reads (wrapping at MEM_DEPTH-1).
module spi_slave_ram_param
    import spi_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_DEPTH  = 2**ADDR_WIDTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       SS_n,
    input  logic       MOSI,
    output logic       MISO,
    output logic       busy,
    output logic       frame_err,
    output logic [2:0] dbg_state_o
);

    localparam int FRAME_BITS = DATA_WIDTH + 2;
    localparam int CW         = $clog2(FRAME_BITS + 2);
    localparam int TW         = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FRAME_BITS);
    localparam logic [CW-1:0] DONE_CNT = CW'(FRAME_BITS + 1);

    spi_state_e              state_q, state_d;
    logic [FRAME_BITS-1:0]   rx_sh_q, rx_sh_d;
    logic [CW-1:0]           rx_cnt_q, rx_cnt_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic                    rd_seen_q, rd_seen_d;
    logic                    err_q, err_d;
    logic                    rd_pend_q, rd_pend_d;
    logic [DATA_WIDTH-1:0]   tx_sh_q, tx_sh_d;
    logic [TW-1:0]           tx_cnt_q, tx_cnt_d;
    logic                    miso_q, miso_d;

    logic                    ram_we, ram_re;
    logic [ADDR_WIDTH-1:0]   ram_addr;
    logic [DATA_WIDTH-1:0]   ram_rdata;

    logic                    rx_state, frame_full, dir_ok;
    logic [1:0]              cmd;
    logic [DATA_WIDTH-1:0]   payload;

`ifdef SPI_RAM_AUTOINC_EN
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
        return (a == ADDR_WIDTH'(MEM_DEPTH - 1)) ? '0 : a + 1'b1;
    endfunction
`endif

    assign rx_state   = (state_q == ST_WRITE) || (state_q == ST_READ_ADD) ||
                        (state_q == ST_READ_DATA);
    assign frame_full = rx_state && (rx_cnt_q == FULL_CNT);
    assign cmd        = rx_sh_q[FRAME_BITS-1 -: 2];
    assign payload    = rx_sh_q[DATA_WIDTH-1:0];
    // The direction bit chose the state; cmd[1] must agree with it.
    assign dir_ok     = (cmd[1] == (state_q != ST_WRITE));

    always_comb begin
        state_d   = state_q;
        rx_sh_d   = rx_sh_q;
        rx_cnt_d  = rx_cnt_q;
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        rd_seen_d = rd_seen_q;
        err_d     = 1'b0;
        rd_pend_d = 1'b0;
        tx_sh_d   = tx_sh_q;
        tx_cnt_d  = tx_cnt_q;
        miso_d    = 1'b0;
        ram_we    = 1'b0;
        ram_re    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!SS_n) begin
                    state_d  = ST_CHK_CMD;
                    rx_cnt_d = '0;
                end
            end
            ST_CHK_CMD: begin
                if (SS_n) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else if (MOSI) begin
                    state_d = rd_seen_q ? ST_READ_DATA : ST_READ_ADD;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
                if (rx_cnt_q < FULL_CNT) begin
                    if (SS_n) begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end else begin
                        rx_sh_d  = {rx_sh_q[FRAME_BITS-2:0], MOSI};
                        rx_cnt_d = rx_cnt_q + 1'b1;
                    end
                end else begin
                    // Saturate past FULL_CNT so the command runs exactly once.
                    rx_cnt_d = DONE_CNT;
                    if (SS_n) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (frame_full && dir_ok) begin
            case (cmd)
                CMD_WR_ADDR: wr_addr_d = payload[ADDR_WIDTH-1:0];
                CMD_WR_DATA: begin
                    ram_we = 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
                    wr_addr_d = next_addr(wr_addr_q);
`endif
                end
                CMD_RD_ADDR: begin
                    rd_addr_d = payload[ADDR_WIDTH-1:0];
                    rd_seen_d = 1'b1;
                end
                default: begin
                    ram_re    = 1'b1;
                    rd_pend_d = !SS_n;
`ifdef SPI_RAM_AUTOINC_EN
                    rd_seen_d = 1'b1;
                    rd_addr_d = next_addr(rd_addr_q);
`else
                    rd_seen_d = 1'b0;
`endif
                end
            endcase
        end

        // Shift-out: first bit appears the edge after the RAM read returns.
        if (rd_pend_q) begin
            miso_d   = ram_rdata[DATA_WIDTH-1];
            tx_sh_d  = {ram_rdata[DATA_WIDTH-2:0], 1'b0};
            tx_cnt_d = TW'(DATA_WIDTH - 1);
        end else if (tx_cnt_q != '0) begin
            miso_d   = tx_sh_q[DATA_WIDTH-1];
            tx_sh_d  = {tx_sh_q[DATA_WIDTH-2:0], 1'b0};
            tx_cnt_d = tx_cnt_q - 1'b1;
        end

        // Deselect truncates any output in flight.
        if (SS_n) begin
            miso_d   = 1'b0;
            tx_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rx_sh_q   <= '0;
            rx_cnt_q  <= '0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            rd_seen_q <= 1'b0;
            err_q     <= 1'b0;
            rd_pend_q <= 1'b0;
            tx_sh_q   <= '0;
            tx_cnt_q  <= '0;
            miso_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_sh_q   <= rx_sh_d;
            rx_cnt_q  <= rx_cnt_d;
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            rd_seen_q <= rd_seen_d;
            err_q     <= err_d;
            rd_pend_q <= rd_pend_d;
            tx_sh_q   <= tx_sh_d;
            tx_cnt_q  <= tx_cnt_d;
            miso_q    <= miso_d;
        end
    end

    assign ram_addr = ram_we ? wr_addr_q : rd_addr_q;

    spi_ram_sp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (ram_addr),
        .wdata_i (payload),
        .rdata_o (ram_rdata)
    );

    assign MISO        = miso_q;
    assign busy        = (state_q != ST_IDLE);
    assign frame_err   = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_slave_ram_param.sv
// Bench for spi_slave_ram_param: two instances (8/8 default and 16/10),
// driven one at a time. A reference model of the RAM and address registers
// predicts each read word; a monitor collects MISO bits and compares.
module tb_spi_slave_ram_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] ss_n;
  logic [1:0] mosi;
  logic       miso0, busy0, ferr0, miso1, busy1, ferr1;
  logic [2:0] dbg0, dbg1;
  logic [1:0] miso_v, busy_v, ferr_v;

  assign miso_v = {miso1, miso0};
  assign busy_v = {busy1, busy0};
  assign ferr_v = {ferr1, ferr0};

  spi_slave_ram_param u_dut8 (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_n[0]), .MOSI(mosi[0]),
    .MISO(miso0), .busy(busy0), .frame_err(ferr0), .dbg_state_o(dbg0)
  );

  spi_slave_ram_param #(.DATA_WIDTH(16), .ADDR_WIDTH(10)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_n[1]), .MOSI(mosi[1]),
    .MISO(miso1), .busy(busy1), .frame_err(ferr1), .dbg_state_o(dbg1)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  int         dwid [2];
  int         depth [2];
  logic [15:0] mem [2][1024];
  bit         known [2][1024];
  int         wa [2];
  int         ra [2];
  int         exp_err [2];
  int         seen_err [2];

  typedef struct { int d; int start; logic [15:0] word; } rd_t;
  rd_t exp_q[$];

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      wa[d] = 0;
      ra[d] = 0;
    end
  endfunction

  // Applies a completed frame; hold=1 means SS_n stays low for read-out.
  function automatic void model_exec(input int d, input bit dir, input logic [1:0] cmd,
                                     input logic [15:0] pl, input bit hold);
    logic [15:0] plm;
    int a;
    rd_t e;
    if (cmd[1] != dir) return;
    plm = (dwid[d] == 16) ? pl : {8'h00, pl[7:0]};
    a   = int'(pl) % depth[d];
    case (cmd)
      2'b00: wa[d] = a;
      2'b01: begin
        mem[d][wa[d]]   = plm;
        known[d][wa[d]] = 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
        wa[d] = (wa[d] + 1) % depth[d];
`endif
      end
      2'b10: ra[d] = a;
      default: begin
        if (hold && known[d][ra[d]]) begin
          e.d = d; e.start = cyc + 2; e.word = mem[d][ra[d]];
          exp_q.push_back(e);
        end
`ifdef SPI_RAM_AUTOINC_EN
        ra[d] = (ra[d] + 1) % depth[d];
`endif
      end
    endcase
  endfunction

  // ---------------- driver ----------------
  // stop_at: bit index at which the frame is cut (SS_n high or reset);
  // stop_at == nbits is a normal end with SS_n high on the execute edge;
  // stop_at > nbits keeps SS_n low through the read-out.
  task automatic frame(input int d, input bit dir, input logic [1:0] cmd,
                       input logic [15:0] pl, input int stop_at, input bit by_rst);
    int w = dwid[d];
    int nbits = w + 2;
    logic b;
    @(negedge clk);
    ss_n[d] = 1'b0;
    mosi[d] = 1'b0;
    @(negedge clk);
    check("busy_start", busy_v[d], 1'b1);
    mosi[d] = dir;
    for (int k = 0; k <= nbits; k++) begin
      @(negedge clk);
      if (k == stop_at) begin
        if (by_rst) begin
          rst_n = 1'b0;
          ss_n[d] = 1'b1;
          model_reset();
          @(negedge clk);
          check("rst_miso", miso_v[d], 1'b0);
          check("rst_busy", busy_v[d], 1'b0);
          check("rst_ferr", ferr_v[d], 1'b0);
          rst_n = 1'b1;
        end else begin
          ss_n[d] = 1'b1;
          if (k < nbits) exp_err[d]++;
          else model_exec(d, dir, cmd, pl, 1'b0);
          @(negedge clk);
          check("busy_end", busy_v[d], 1'b0);
        end
        return;
      end
      if (k < nbits) begin
        if (k == 0) b = cmd[1];
        else if (k == 1) b = cmd[0];
        else b = pl[w + 1 - k];
        mosi[d] = b;
      end
    end
    model_exec(d, dir, cmd, pl, 1'b1);
    repeat (w + 2) @(negedge clk);
    ss_n[d] = 1'b1;
    @(negedge clk);
    check("busy_end", busy_v[d], 1'b0);
  endtask

  task automatic wr(input int d, input logic [1:0] cmd, input logic [15:0] pl);
    frame(d, cmd[1], cmd, pl, dwid[d] + 2, 1'b0);
  endtask

  task automatic rd(input int d);
    frame(d, 1'b1, 2'b11, 16'h0000, dwid[d] + 3, 1'b0);
  endtask

  // ---------------- monitors ----------------
  initial begin
    rd_t cur;
    bit active = 1'b0;
    int nb = 0;
    logic [15:0] got = '0;
    forever begin
      @(negedge clk);
      if (!active && exp_q.size() > 0 && cyc == exp_q[0].start) begin
        cur = exp_q.pop_front();
        active = 1'b1;
        nb = 0;
        got = '0;
      end
      if (active) begin
        if (nb < dwid[cur.d]) begin
          got = {got[14:0], miso_v[cur.d]};
          nb++;
          if (nb == dwid[cur.d]) check("rd_word", got, cur.word);
        end else begin
          check("miso_after", miso_v[cur.d], 1'b0);
          active = 1'b0;
        end
      end
    end
  end

  initial begin
    logic [1:0] prev = 2'b00;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (ferr_v[d] === 1'b1) begin
          seen_err[d]++;
          check("ferr_width", prev[d], 1'b0);
        end
      end
      prev = ferr_v;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    dwid[0] = 8;   dwid[1] = 16;
    depth[0] = 256; depth[1] = 1024;
    for (int d = 0; d < 2; d++) begin
      exp_err[d] = 0; seen_err[d] = 0;
      for (int i = 0; i < 1024; i++) known[d][i] = 1'b0;
    end
    model_reset();
    rst_n = 1'b0;
    ss_n = 2'b11;
    mosi = 2'b00;
    repeat (3) @(negedge clk);
    check("reset_miso8", miso0, 1'b0);
    check("reset_busy8", busy0, 1'b0);
    check("reset_ferr8", ferr0, 1'b0);
    check("reset_miso16", miso1, 1'b0);
    check("reset_busy16", busy1, 1'b0);
    check("reset_ferr16", ferr1, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic write/read: expect AAh out.
    wr(0, 2'b00, 16'h55); wr(0, 2'b01, 16'hAA); wr(0, 2'b10, 16'h55); rd(0);

    // Aborted write leaves the old value.
    wr(0, 2'b00, 16'h40); wr(0, 2'b01, 16'h77);
    wr(0, 2'b00, 16'h40);
    frame(0, 1'b0, 2'b01, 16'h33, 5, 1'b0);
    wr(0, 2'b10, 16'h40); rd(0);

    // Direction bit disagrees with cmd[1]: discarded.
    frame(0, 1'b1, 2'b01, 16'hEE, 10, 1'b0);
    wr(0, 2'b10, 16'h40); rd(0);

    // Top-of-memory writes (wrap when auto-increment is built in).
    wr(0, 2'b00, 16'h00); wr(0, 2'b01, 16'h99);
    wr(0, 2'b00, 16'hFF); wr(0, 2'b01, 16'h11); wr(0, 2'b01, 16'h22);
    wr(0, 2'b10, 16'hFF); rd(0);
    wr(0, 2'b10, 16'h00); rd(0);

    // Reset just before the execute edge: no write, registers cleared.
    wr(0, 2'b00, 16'h10); wr(0, 2'b01, 16'h5A);
    frame(0, 1'b0, 2'b01, 16'hC3, 10, 1'b1);
    wr(0, 2'b01, 16'h3C);
    wr(0, 2'b10, 16'h10); rd(0);
    wr(0, 2'b10, 16'h00); rd(0);

    // Wide instance.
    wr(1, 2'b00, 16'h3FF); wr(1, 2'b01, 16'hBEEF); wr(1, 2'b10, 16'h3FF); rd(1);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      int d, r, nbits;
      logic [1:0] cmd;
      logic [15:0] pl;
      bit dir;
      d = $urandom_range(0, 1);
      r = $urandom_range(0, 9);
      nbits = dwid[d] + 2;
      cmd = 2'($urandom_range(0, 3));
      pl = cmd[0] ? 16'($urandom) : 16'($urandom_range(0, 7));
      if (cmd == 2'b11 && !known[d][ra[d]]) cmd = 2'b01;
      dir = (r == 0) ? !cmd[1] : cmd[1];
      if (r == 1) frame(d, dir, cmd, pl, $urandom_range(0, nbits - 1), 1'b0);
      else if (cmd == 2'b11) frame(d, dir, cmd, pl, nbits + 1, 1'b0);
      else frame(d, dir, cmd, pl, nbits, 1'b0);
    end

    for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    check("reads_drained", exp_q.size(), 0);
    check("ferr_count8", seen_err[0], exp_err[0]);
    check("ferr_count16", seen_err[1], exp_err[1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
